// File: rtl/flash_sequencer.sv
// Purpose : scoreboard flash controller; blanks the captured digit mask for FLASHES off/on pairs,
//           pacing each phase with a start/done handshake to an external flash timer.
// Latency : outputs registered; trigger at edge N -> timer_start/busy/blank at N+1; finished one
//           edge after the last timer_done, busy falls the edge after that.
// Backpressure: no queuing; trigger is honoured only in IDLE, timer_done only in WAIT.
// Ports   : CLK_50MHZ/RST (async active-low) | trigger, mask[7:0] request side |
//           timer_start/timer_done flash timer handshake | blank[7:0] to display mux |
//           busy, finished, err status.
// Option  : define FLASH_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles and raise sticky err.
module flash_sequencer #(
  parameter int FLASHES = 3,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       trigger,
  input  logic [7:0] mask,
  output logic       timer_start,
  input  logic       timer_done,
  output logic [7:0] blank,
  output logic       busy,
  output logic       finished,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  // Off and on phases alternate, so phase 2*FLASHES-1 is the final on phase.
  localparam logic [3:0] LAST_PHASE = 4'(2 * FLASHES - 1);

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] phase_q, phase_d;
  logic       err_q, err_d;
  logic       timer_start_q, timer_start_d;
  logic [7:0] blank_q, blank_d;
  logic       busy_q, busy_d;
  logic       finished_q, finished_d;

`ifdef FLASH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
  logic [7:0] wait_cnt_q, wait_cnt_d;
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT[7:0];
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    phase_d = phase_q;
    err_d   = err_q;
`ifdef FLASH_TIMEOUT_EN
    // Counts WAIT cycles; START always precedes WAIT so it enters WAIT at zero.
    wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
`endif

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = START;
          mask_d  = mask;
          phase_d = 4'd0;
          err_d   = 1'b0;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // timer_done is checked first so a reply on the timeout cycle still completes normally.
        if (timer_done) begin
          if (phase_q == LAST_PHASE) begin
            state_d = DONE;
          end else begin
            phase_d = phase_q + 4'd1;
            state_d = START;
          end
        end
`ifdef FLASH_TIMEOUT_EN
        else if (wait_cnt_d == TIMEOUT_CNT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    timer_start_d = (state_d == START);
    blank_d       = ((state_d == START || state_d == WAIT) && !phase_d[0]) ? mask_d : 8'h00;
    busy_d        = (state_d != IDLE);
    finished_d    = (state_d == DONE);
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      mask_q        <= 8'h00;
      phase_q       <= 4'd0;
      err_q         <= 1'b0;
      timer_start_q <= 1'b0;
      blank_q       <= 8'h00;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
`ifdef FLASH_TIMEOUT_EN
      wait_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      phase_q       <= phase_d;
      err_q         <= err_d;
      timer_start_q <= timer_start_d;
      blank_q       <= blank_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
`ifdef FLASH_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

  assign timer_start = timer_start_q;
  assign blank       = blank_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
`ifdef FLASH_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_flash_sequencer.sv
module tb_flash_sequencer;
  localparam int F  = 3;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trigger = 1'b0;
  logic       timer_done = 1'b0;
  logic [7:0] mask = 8'h00;
  logic       timer_start, busy, finished, err;
  logic [7:0] blank;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flash_sequencer #(.FLASHES(F), .TIMEOUT(TO)) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst_n),
    .trigger    (trigger),
    .mask       (mask),
    .timer_start(timer_start),
    .timer_done (timer_done),
    .blank      (blank),
    .busy       (busy),
    .finished   (finished),
    .err        (err)
  );

  // Observed vector: {timer_start, blank, busy, finished, err}
  task automatic check(input string tag, input logic [11:0] exp);
    n_cmp++;
    assert ({timer_start, blank, busy, finished, err} === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, {timer_start, blank, busy, finished, err}, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: phase p starts at relative cycle s[p] and its timer answers d[p] cycles
  // later, so the next phase starts d[p]+1 cycles after s[p]. Cycle 0 is the trigger cycle.
  // abort_at > 0 applies reset during the cycle of that timer_start pulse.
  task automatic run_flash(input logic [7:0] m, input int dmin, input int dmax,
                           input bit noise, input int abort_at);
    int d[2*F];
    int s[2*F+1];
    int done_c;
    int starts_seen;
    logic       e_start;
    logic [7:0] e_blank;
    starts_seen = 0;
    s[0] = 1;
    for (int p = 0; p < 2*F; p++) begin
      d[p]     = $urandom_range(dmax, dmin);
      s[p + 1] = s[p] + d[p] + 1;
    end
    done_c     = s[2*F];
    trigger    = 1'b1;
    mask       = m;
    timer_done = 1'b0;
    for (int k = 1; k <= done_c + 1; k++) begin
      step();
      e_start = 1'b0;
      e_blank = 8'h00;
      for (int p = 0; p < 2*F; p++) begin
        if (k == s[p]) e_start = 1'b1;
        if (k >= s[p] && k <= s[p] + d[p] && (p % 2) == 0) e_blank = m;
      end
      check("run", {e_start, e_blank, (k <= done_c), (k == done_c), 1'b0});
      if (timer_start === 1'b1) starts_seen++;
      if (abort_at > 0 && k == s[abort_at - 1]) begin
        rst_n = 1'b0;
        #1;
        check("midrst_now", 12'h000);
        step();
        check("midrst_held", 12'h000);
        trigger    = 1'b0;
        timer_done = 1'b0;
        rst_n      = 1'b1;
        return;
      end
      // Inputs for this cycle: mask wanders after capture; triggers and stray dones are noise.
      mask       = (noise) ? 8'hF0 : 8'($urandom);
      trigger    = noise && (k <= done_c) && ($urandom_range(2, 0) == 0);
      timer_done = 1'b0;
      for (int p = 0; p < 2*F; p++) begin
        if (k == s[p] + d[p]) timer_done = 1'b1;
        if (noise && k == s[p]) timer_done = 1'b1;  // lands in a START cycle
      end
    end
    trigger    = 1'b0;
    timer_done = 1'b0;
    check_int("start_count", starts_seen, 2*F);
  endtask

  initial begin
    // Reset held with trigger high.
    rst_n   = 1'b0;
    trigger = 1'b1;
    mask    = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset", 12'h000);
    end
    trigger = 1'b0;
    rst_n   = 1'b1;
    step();
    check("idle_after_reset", 12'h000);

    // Normal run, timer answers 4 cycles after each start.
    run_flash(8'h0F, 4, 4, 1'b0, 0);
    // Same with triggers (mask F0) and stray dones during the sequence.
    run_flash(8'h0F, 4, 4, 1'b1, 0);

    // Stray done while idle.
    timer_done = 1'b1;
    step();
    check("stray_done_idle", 12'h000);
    timer_done = 1'b0;
    run_flash(8'($urandom), 1, 6, 1'b1, 0);

    // Empty mask still runs the handshake.
    run_flash(8'h00, 1, 5, 1'b1, 0);

    // Timer reply on exactly the TIMEOUT-th wait cycle completes normally.
    run_flash(8'h81, TO, TO, 1'b0, 0);

    // Reset during the 3rd phase, then a fresh run starts from phase 0.
    run_flash(8'h3C, 2, 5, 1'b0, 3);
    step();
    check("idle_after_midrst", 12'h000);
    run_flash(8'h3C, 1, 5, 1'b0, 0);

    for (int r = 0; r < 4; r++) run_flash(8'($urandom), 1, 8, 1'b1, 0);

    // Timer never answers.
    trigger = 1'b1;
    mask    = 8'hA5;
    step();
    trigger = 1'b0;
    check("to_start", {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0});
`ifdef FLASH_TIMEOUT_EN
    for (int k = 2; k <= TO + 1; k++) begin
      step();
      check("to_wait", {1'b0, 8'hA5, 1'b1, 1'b0, 1'b0});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check("to_err", {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    end
`else
    for (int k = 2; k <= 40; k++) begin
      step();
      check("to_stuck", {1'b0, 8'hA5, 1'b1, 1'b0, 1'b0});
    end
    rst_n = 1'b0;
    #1;
    check("to_rst", 12'h000);
    step();
    rst_n = 1'b1;
`endif
    // Next accepted trigger clears err (checked each cycle of the run).
    run_flash(8'h5A, 1, 4, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
